dm_port_arbiter: RTL

- Shares the single data-memory port (cslt/wrb/address/write-data in, registered read-data out) between two requesters: the processor core (DAG/bus-connect path) and a host/DMA requester.
- Core has fixed priority. A starvation counter forces one host slot after a bounded wait.
- Re-times write data to the memory's execute+1 write cycle.
- Tags every read and routes the returned read data to its owner.

---
 rtl/dm_arb_pkg.sv | 15 +
 rtl/dm_arb_starve_cnt.sv | 45 ++++
 rtl/dm_port_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
// Owner tags mark which requester a read in flight belongs to.
// The *_DEF constants are the default widths used by the top.
package dm_arb_pkg;

  localparam int unsigned DMA_SIZE_DEF     = 16;
  localparam int unsigned DMD_SIZE_DEF     = 16;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned CNT_W_DEF        = 4;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_HOST = 2'd2;

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// Saturating starvation counter for the host requester.
// Ports:
//   clk, reset      clock and asynchronous active-low reset
//   host_req        host is requesting the port
//   core_req        core is requesting the port
//   host_gnt        host won the port this cycle
//   force_host      host has waited STARVE_LIMIT cycles and must win now
// STARVE_LIMIT = 0 disables forcing. 2**CNT_W must exceed STARVE_LIMIT.
module dm_arb_starve_cnt #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic host_req,
  input  logic core_req,
  input  logic host_gnt,
  output logic force_host
);

  localparam logic [CNT_W-1:0] LimitCnt = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign force_host = (STARVE_LIMIT != 0) && (wait_cnt_q == LimitCnt);

  always_comb begin
    wait_cnt_d = '0;
    if (host_gnt) begin
      wait_cnt_d = '0;
    end else if (host_req && core_req) begin
      // Saturate at the limit; with a zero limit the count simply stays at 0.
      wait_cnt_d = (wait_cnt_q == LimitCnt) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single data-memory port between the core and a host/DMA requester.
// The core has fixed priority; the host is forced in after a bounded wait.
// Write data is re-timed to the memory's execute+1 write cycle, and each read
// is tagged so the registered read data returns to its owner one cycle later.
// Ports:
//   clk, reset                 clock and asynchronous active-low reset
//   core_req/wr/addr/wdata     core access request
//   core_stall                 core request not accepted this cycle
//   core_rdata, core_rvalid    core read return
//   host_req/wr/addr/wdata     host access request, held until host_gnt
//   host_gnt                   host request accepted this cycle
//   host_rdata, host_rvalid    host read return
//   mem_cslt/wrb/add/wdata     memory port drive
//   mem_rdata                  memory registered read data
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned DMA_SIZE     = DMA_SIZE_DEF,
  parameter int unsigned DMD_SIZE     = DMD_SIZE_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                core_req,
  input  logic                core_wr,
  input  logic [DMA_SIZE-1:0] core_addr,
  input  logic [DMD_SIZE-1:0] core_wdata,
  output logic                core_stall,
  output logic [DMD_SIZE-1:0] core_rdata,
  output logic                core_rvalid,
  input  logic                host_req,
  input  logic                host_wr,
  input  logic [DMA_SIZE-1:0] host_addr,
  input  logic [DMD_SIZE-1:0] host_wdata,
  output logic                host_gnt,
  output logic [DMD_SIZE-1:0] host_rdata,
  output logic                host_rvalid,
  output logic                mem_cslt,
  output logic                mem_wrb,
  output logic [DMA_SIZE-1:0] mem_add,
  output logic [DMD_SIZE-1:0] mem_wdata,
  input  logic [DMD_SIZE-1:0] mem_rdata
);

  logic                force_host;
  logic                core_gnt;
  logic [1:0]          tag_q, tag_d;
  logic [DMD_SIZE-1:0] wdata_q, wdata_d;
  logic [DMD_SIZE-1:0] core_rdata_q, core_rdata_d;
  logic [DMD_SIZE-1:0] host_rdata_q, host_rdata_d;

  dm_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .host_req  (host_req),
    .core_req  (core_req),
    .host_gnt  (host_gnt),
    .force_host(force_host)
  );

  assign host_gnt   = host_req && (!core_req || force_host);
  assign core_gnt   = core_req && !host_gnt;
  assign core_stall = core_req && host_gnt;

  always_comb begin
    mem_cslt = 1'b0;
    mem_wrb  = 1'b0;
    mem_add  = '0;
    wdata_d  = wdata_q;
    tag_d    = OWN_NONE;
    if (host_gnt) begin
      mem_cslt = 1'b1;
      mem_wrb  = host_wr;
      mem_add  = host_addr;
      if (host_wr) wdata_d = host_wdata;
      else         tag_d   = OWN_HOST;
    end else if (core_gnt) begin
      mem_cslt = 1'b1;
      mem_wrb  = core_wr;
      mem_add  = core_addr;
      if (core_wr) wdata_d = core_wdata;
      else         tag_d   = OWN_CORE;
    end
  end

  // Registered write data lines up with the memory's commit in the next cycle.
  assign mem_wdata = wdata_q;

  // Read data is passed straight through in the return cycle; the hold
  // registers keep the last value for the requester that did not read.
  assign core_rvalid  = (tag_q == OWN_CORE);
  assign host_rvalid  = (tag_q == OWN_HOST);
  assign core_rdata_d = core_rvalid ? mem_rdata : core_rdata_q;
  assign host_rdata_d = host_rvalid ? mem_rdata : host_rdata_q;
  assign core_rdata   = core_rdata_d;
  assign host_rdata   = host_rdata_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q        <= OWN_NONE;
      wdata_q      <= '0;
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      tag_q        <= tag_d;
      wdata_q      <= wdata_d;
      core_rdata_q <= core_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

endmodule
